// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the shared-ALU arbiter: default
//                datapath width, logic-ALU opcode values and the arbiter
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Default operand/result width of the shared ALU.
    localparam int WIDTH_DEFAULT = 8;

    // Legal opcodes; every other 3-bit code is reported as illegal.
    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b100;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Purely combinational 8-bit logic ALU (NOT/AND/OR/XOR).
//                Unknown opcodes produce zero and raise 'illegal'.
//  Ports       : a, b     - operands
//                op       - 3-bit opcode
//                y        - result
//                illegal  - high when op is not a recognised opcode
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             illegal
);

    always_comb begin
        y       = '0;
        illegal = 1'b0;
        case (op)
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: illegal = 1'b1;
        endcase
    end

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arbiter
//  Description : Round-robin arbiter/sequencer sharing one logic ALU between
//                two requesters. IDLE grants a requester and latches its
//                operands, EXEC loads the registered result, DONE pulses the
//                winner's done for one cycle.
//  Ports       : clk, reset          - clock, async active-high reset
//                req0/req1           - level requests
//                a0,b0,op0/a1,b1,op1 - per-requester operands and opcode
//                gnt                 - one-hot grant (high during EXEC)
//                done0/done1         - one-cycle completion pulses
//                result, err         - registered ALU result and illegal flag
//                busy                - high in EXEC and DONE
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [2:0]       op0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [2:0]       op1,
    output logic [1:0]       gnt,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             busy
);

    state_t             state_q, state_d;
    logic               sel_q;      // requester currently being served
    logic               ptr_q;      // requester favoured on a tie
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   result_q;
    logic               err_q;

    logic               grant_w;
    logic               win_w;
    logic [WIDTH-1:0]   alu_y_w;
    logic               alu_illegal_w;

    // ALU only ever sees the latched operands, so requester-side changes
    // after the grant cannot disturb the operation in flight.
    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .a       (a_q),
        .b       (b_q),
        .op      (op_q),
        .y       (alu_y_w),
        .illegal (alu_illegal_w)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sel_q    <= 1'b0;
            ptr_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_w) begin
                sel_q <= win_w;
                a_q   <= win_w ? a1  : a0;
                b_q   <= win_w ? b1  : b0;
                op_q  <= win_w ? op1 : op0;
            end
            if (state_q == ST_EXEC) begin
                result_q <= alu_y_w;
                err_q    <= alu_illegal_w;
                ptr_q    <= ~sel_q;   // other side wins the next tie
            end
        end
    end

    // Next-state and winner selection.
    always_comb begin
        state_d = state_q;
        grant_w = 1'b0;
        win_w   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    grant_w = 1'b1;
                    win_w   = (req0 && req1) ? ptr_q : req1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;   // requests ignored here
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        gnt   = 2'b00;
        done0 = 1'b0;
        done1 = 1'b0;
        busy  = 1'b0;
        case (state_q)
            ST_EXEC: begin
                gnt  = sel_q ? 2'b10 : 2'b01;
                busy = 1'b1;
            end
            ST_DONE: begin
                done0 = ~sel_q;
                done1 = sel_q;
                busy  = 1'b1;
            end
            default: ;
        endcase
    end

    assign result = result_q;
    assign err    = err_q;

endmodule : alu_share_arbiter
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_share_arbiter
//  Description : Self-checking bench for alu_share_arbiter: directed
//                scenarios followed by randomized request traffic compared
//                against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic [2:0]   op0, op1;
    logic [1:0]   gnt;
    logic         done0, done1;
    logic [W-1:0] result;
    logic         err;
    logic         busy;

    int nvec  = 0;
    int nfail = 0;
    int last_served = 1;   // model: favours requester 0 after reset

    alu_share_arbiter #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .req1   (req1),
        .a0     (a0),
        .b0     (b0),
        .op0    (op0),
        .a1     (a1),
        .b1     (b1),
        .op1    (op1),
        .gnt    (gnt),
        .done0  (done0),
        .done1  (done1),
        .result (result),
        .err    (err),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference ALU: returns {err, result}.
    function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return {1'b0, ~a};
            3'd1:    return {1'b0, a & b};
            3'd2:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            default: return 9'h100;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full grant/exec/done transaction starting in IDLE with the
    // requests already driven. The winner drops its request in DONE
    // unless 'hold' is set.
    task automatic serve(input bit hold);
        int w;
        logic [8:0] e;
        w = (req0 && req1) ? (last_served == 0 ? 1 : 0) : (req1 ? 1 : 0);
        e = (w == 0) ? ref_alu(a0, b0, op0) : ref_alu(a1, b1, op1);
        step();
        check("gnt", {30'd0, gnt}, (w == 0) ? 32'd1 : 32'd2);
        check("busy_exec", {31'd0, busy}, 32'd1);
        check("done_exec", {30'd0, done1, done0}, 32'd0);
        // Disturb winner's inputs during EXEC; must not affect result.
        if (w == 0) begin a0 = W'($urandom); b0 = W'($urandom); op0 = 3'($urandom); end
        else        begin a1 = W'($urandom); b1 = W'($urandom); op1 = 3'($urandom); end
        step();
        check("done", {30'd0, done1, done0}, (w == 0) ? 32'd1 : 32'd2);
        check("gnt_done", {30'd0, gnt}, 32'd0);
        check("result", {24'd0, result}, {24'd0, e[7:0]});
        check("err", {31'd0, err}, {31'd0, e[8]});
        if (!hold) begin
            if (w == 0) req0 = 1'b0; else req1 = 1'b0;
        end
        last_served = w;
        step();
        check("done_clr", {30'd0, done1, done0}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("result_hold", {24'd0, result}, {24'd0, e[7:0]});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        last_served = 1;
        step();
    endtask

    initial begin
        logic [2:0] ops [3];
        logic [7:0] exps [3];
        reset = 1'b0;
        req0 = 0; req1 = 0;
        a0 = '0; b0 = '0; op0 = '0; a1 = '0; b1 = '0; op1 = '0;
        #2;
        do_reset();
        check("rst_gnt", {30'd0, gnt}, 32'd0);
        check("rst_done", {30'd0, done1, done0}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // Single request, AND; also exercises operand isolation.
        a0 = 8'h56; b0 = 8'hB5; op0 = 3'b001; req0 = 1;
        serve(0);
        check("and_const", {24'd0, result}, 32'h14);

        // Legal opcodes on requester 1.
        ops[0] = 3'b000; ops[1] = 3'b010; ops[2] = 3'b100;
        exps[0] = 8'hA9; exps[1] = 8'hF7; exps[2] = 8'hE3;
        for (int i = 0; i < 3; i++) begin
            a1 = 8'h56; b1 = 8'hB5; op1 = ops[i]; req1 = 1;
            serve(0);
            check("op1_const", {24'd0, result}, {24'd0, exps[i]});
        end

        // Illegal opcode.
        a0 = 8'h56; b0 = 8'hB5; op0 = 3'b011; req0 = 1;
        serve(0);
        check("illegal_err", {31'd0, err}, 32'd1);

        // Simultaneous held requests after reset: 0, 1, 0.
        do_reset();
        a0 = 8'h0F; b0 = 8'h3C; op0 = 3'b100;
        a1 = 8'hF0; b1 = 8'h55; op1 = 3'b001;
        req0 = 1; req1 = 1;
        serve(1);
        serve(1);
        serve(1);
        req0 = 0; req1 = 0;

        // Reset during EXEC.
        a0 = 8'h56; b0 = 8'hB5; op0 = 3'b010; req0 = 1;
        step();
        check("pre_rst_gnt", {30'd0, gnt}, 32'd1);
        reset = 1'b1;
        req0 = 0;
        #1;
        check("arst_gnt", {30'd0, gnt}, 32'd0);
        check("arst_done", {30'd0, done1, done0}, 32'd0);
        check("arst_result", {24'd0, result}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        step();
        reset = 1'b0;
        last_served = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_done_after_rst", {30'd0, done1, done0}, 32'd0);
        end
        a1 = 8'h56; b1 = 8'hB5; op1 = 3'b100; req1 = 1;
        serve(0);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            if (!req0 && ($urandom_range(0, 2) != 0)) begin
                a0 = W'($urandom); b0 = W'($urandom); op0 = 3'($urandom); req0 = 1;
            end
            if (!req1 && ($urandom_range(0, 2) != 0)) begin
                a1 = W'($urandom); b1 = W'($urandom); op1 = 3'($urandom); req1 = 1;
            end
            if (req0 || req1) begin
                serve(1'($urandom_range(0, 3) == 0));
            end else begin
                step();
                check("idle_gnt", {30'd0, gnt}, 32'd0);
                check("idle_busy", {31'd0, busy}, 32'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule : tb_alu_share_arbiter
`default_nettype wire
